fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the decoder. Owns the PC and
//  issues word reads to a synchronous instruction memory with fixed 1-cycle
//  latency. Buffers returned words in a 2-entry queue and presents {instr, pc}
//  to decode over a valid/ready handshake. Handles redirects from execute:
//  flushes queued words and drops the word still in flight.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  imem_en        out  1     read strobe; data returns next cycle
//  imem_addr      out  XLEN  word-aligned read address
//  imem_rdata     in   32    read data, valid the cycle after imem_en
//  redirect_valid in   1     one-cycle pulse: resteer fetch
//  redirect_pc    in   XLEN  new fetch target; bits[1:0] are forced to 0
//  instr_valid    out  1     instr/instr_pc hold a valid word for decode
//  instr          out  32    instruction word to decoder
//  instr_pc       out  XLEN  address of instr
//  instr_ready    in   1     decoder accepts the word this cycle
// BEHAVIOUR
//  Reset: pc=RESET_PC, imem_en=0, imem_addr=RESET_PC, instr_valid=0,
//    instr=32'h0000_0013 (NOP), instr_pc=0, queue empty, inflight=0, epoch=0.
//  FSM: S_BOOT is the state entered on rst. It goes to S_RUN after 1 cycle.
//    imem_en stays 0 in S_BOOT. Redirects in S_BOOT are applied to pc.
//  Issue (S_RUN): imem_en=1 when occ + inflight - pop < 2 and no redirect this
//    cycle. Here pop = instr_valid & instr_ready.
//    On issue: imem_addr=pc, pc<=pc+4 (mod 2^XLEN; 0xFFFF_FFFC wraps to 0).
//    The issue captures inflight<=1 and a tag of the current epoch.
//  Response: in the cycle after an issue, imem_rdata is pushed with its PC if
//    the tag equals epoch; otherwise it is discarded. The queue never
//    overflows, by credit.
//  Output: instr_valid = queue not empty; instr/instr_pc = head entry.
//    The head entry holds stable while instr_valid & !instr_ready.
//    Push and pop in the same cycle are both performed.
//  Latency: address issued in cycle N appears at instr_valid in cycle N+2.
//    First instr_valid is 3 cycles after rst deasserts.
//    Steady state with instr_ready=1 is 1 instruction per cycle.
//  Redirect (priority over pop, push and issue):
//    - queue cleared;
//    - epoch toggled, so the in-flight word is dropped;
//    - pc <= {redirect_pc[XLEN-1:2],2'b00};
//    - imem_en=0 that cycle.
//    instr_valid is 0 in the next cycle. The target is issued the cycle after
//    the redirect and is valid 2 cycles later.
//  A redirect while the queue is empty and nothing is in flight behaves the
//    same way.
//  rst mid-operation overrides everything: the reset state is reached next
//    cycle, and any returning imem_rdata is ignored.
//  Queue-full with instr_ready=0: issue stalls, pc holds, no word is lost or
//    duplicated.
// STRUCTURE
//  cpu_pkg: XLEN, NOP_INSTR=32'h0000_0013, default RESET_PC,
//    fetch FSM state encoding {S_BOOT,S_RUN}.
//  Sub-module fetch_buffer: 2-entry FIFO of {pc,instr} with push, pop,
//    synchronous flush, and occ/empty outputs. Flush wins over push.
//  Top level holds: PC register, FSM, epoch/inflight/tag flops, and the issue
//    credit logic.
// TESTING (imem model: rdata = f(addr); addr 0x0 holds 32'h002081B3 ADD x3,x1,x2)
//  1 rst 2 cycles, then instr_ready=1 -> instr_valid first high 3 cycles
//    after rst low. instr_pc runs 0x0,0x4,0x8,... on consecutive cycles, and
//    instr at pc 0x0 is 32'h002081B3.
//  2 instr_ready=0 for 6 cycles -> instr/instr_pc are stable. imem_en drops
//    once 2 words are held. After release, the PCs continue in order with no
//    gap or duplicate.
//  3 redirect_valid with redirect_pc=0x100 while 1 word is queued and 1 is in
//    flight -> instr_valid=0 next cycle. The next valid instr_pc is 0x100 and
//    no stale word appears.
//  4 redirect_pc=0x103 -> imem_addr=0x100 and instr_pc=0x100.
//  5 RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence is FFFF_FFF8, FFFF_FFFC,
//    0000_0000.
//  6 rst asserted mid-stream with a word in flight -> the next cycle shows
//    instr_valid=0 and instr=NOP. The returning word is dropped, and fetch
//    restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and state encoding for the front end.
//   XLEN               default datapath / PC width
//   NOP_INSTR          canonical NOP (addi x0,x0,0) shown when nothing is held
//   RESET_PC_DEFAULT   default first fetch address after reset
//   fetch_state_e      fetch FSM states
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instr} between the instruction memory
// response and the decoder.
//   clk, rst            clock and synchronous active-high reset
//   flush               drop all entries (wins over push)
//   push, push_pc/instr write one entry at the tail
//   pop                 remove the head entry
//   head_pc/head_instr  current head entry (undefined contents when empty)
//   occ, empty          number of held entries, and occ == 0
module fetch_buffer #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            pop,
    output logic [PC_W-1:0] head_pc,
    output logic [31:0]     head_instr,
    output logic [1:0]      occ,
    output logic            empty
);

    logic [PC_W-1:0] pc_mem_q    [2];
    logic [PC_W-1:0] pc_mem_d    [2];
    logic [31:0]     instr_mem_q [2];
    logic [31:0]     instr_mem_d [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      occ_q, occ_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        // Guards keep the pointers coherent even if a caller misbehaves;
        // a push into a full buffer is only legal alongside a pop.
        do_pop      = pop && (occ_q != 2'd0);
        do_push     = push && ((occ_q != 2'd2) || do_pop);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (do_push) begin
                pc_mem_d[wr_ptr_q]    = push_pc;
                instr_mem_d[wr_ptr_q] = push_instr;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mem_q[0]    <= '0;
            pc_mem_q[1]    <= '0;
            instr_mem_q[0] <= '0;
            instr_mem_q[1] <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            occ_q          <= 2'd0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign occ        = occ_q;
    assign empty      = (occ_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   clk, rst                     clock, synchronous active-high reset
//   imem_en, imem_addr           word read request (data returns next cycle)
//   imem_rdata                   read data from instruction memory
//   redirect_valid, redirect_pc  one-cycle resteer from execute
//   instr_valid, instr, instr_pc word presented to decode
//   instr_ready                  decoder accepts the presented word
module fetch_unit #(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    import cpu_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            epoch_q, epoch_d;
    logic            tag_q, tag_d;
    logic            inflight_q, inflight_d;

    logic            buf_flush;
    logic            buf_push;
    logic            buf_pop;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;
    logic [1:0]      buf_occ;
    logic            buf_empty;
    logic            credit_ok;

    assign instr_valid = !buf_empty;
    assign buf_pop     = instr_valid && instr_ready;

    // A slot is free if held + returning words, less the one leaving now,
    // stays below the buffer depth; written as a sum to avoid underflow.
    assign credit_ok = ({1'b0, buf_occ} + {2'b00, inflight_q})
                       < (3'd2 + {2'b00, buf_pop});

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        epoch_d    = epoch_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        imem_en    = 1'b0;
        buf_flush  = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!redirect_valid && credit_ok) begin
                    imem_en    = 1'b1;
                    pc_d       = pc_q + XLEN'(4);
                    rsp_pc_d   = pc_q;
                    tag_d      = epoch_q;
                    inflight_d = 1'b1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Toggling the epoch marks whatever is still returning as stale.
        if (redirect_valid) begin
            buf_flush = 1'b1;
            epoch_d   = ~epoch_q;
            pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    assign buf_push  = inflight_q && (tag_q == epoch_q) && !redirect_valid;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= '0;
            epoch_q    <= 1'b0;
            tag_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            epoch_q    <= epoch_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_buffer #(
        .PC_W (XLEN)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (buf_flush),
        .push       (buf_push),
        .push_pc    (rsp_pc_q),
        .push_instr (imem_rdata),
        .pop        (buf_pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .occ        (buf_occ),
        .empty      (buf_empty)
    );

    // Decode sees a NOP at address 0 whenever nothing is held.
    assign instr    = buf_empty ? NOP_INSTR : head_instr;
    assign instr_pc = buf_empty ? '0 : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a main instance at RESET_PC=0 driven by directed
// and random stimulus with a queue-based scoreboard of expected PCs, plus a
// second instance at RESET_PC=FFFF_FFF8 watching the address wrap.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        rst_b = 1'b1;
    logic        imem_en_b;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_rdata_b = 32'hDEAD_BEEF;
    logic        instr_valid_b;
    logic [31:0] instr_b;
    logic [31:0] instr_pc_b;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst_b),
        .imem_en        (imem_en_b),
        .imem_addr      (imem_addr_b),
        .imem_rdata     (imem_rdata_b),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (instr_valid_b),
        .instr          (instr_b),
        .instr_pc       (instr_pc_b),
        .instr_ready    (1'b1)
    );

    // Instruction memory contents are a pure function of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0020_81B3;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One-cycle synchronous memories; unread cycles return garbage.
    always @(posedge clk) begin
        imem_rdata   <= imem_en   ? imem_word(imem_addr)   : 32'hDEAD_BEEF;
        imem_rdata_b <= imem_en_b ? imem_word(imem_addr_b) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: decode must accept PCs in program order from the
    // current start point; every reset or redirect restarts the sequence.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          hs_count = 0;
    int          idle_cnt = 0;
    bit          wd_en = 1'b0;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        refill();
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            logic [31:0] e;
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: unexpected word pc=%h", instr_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("instr_pc", instr_pc, e);
                checkOutput("instr", instr, imem_word(e));
                refill();
            end
        end
        if (wd_en && !rst && !redirect_valid && instr_ready && !instr_valid)
            idle_cnt++;
        else
            idle_cnt = 0;
        if (idle_cnt == 8) begin
            checks++;
            errors++;
            $display("[TB] FAIL watchdog: no word for 8 cycles, got 0 expected 1");
        end
    end

    // Wrap instance: first four accepted PCs must cross the top of memory.
    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int          wrap_idx = 0;

    always @(negedge clk) begin
        if (!rst_b && instr_valid_b && wrap_idx < 4) begin
            checkOutput("wrap_pc", instr_pc_b, wrap_exp[wrap_idx]);
            checkOutput("wrap_instr", instr_b, imem_word(wrap_exp[wrap_idx]));
            wrap_idx++;
        end
    end

    // Drive one cycle of inputs after the edge, then settle past the
    // following falling edge so the monitor has already run.
    task automatic applyStimulus(input logic r, input logic rdy, input logic rv,
                                 input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst            = r;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int hs0;
        logic [31:0] tgt;

        // Reset state and first-fetch latency.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        rst_b = 1'b0;
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 0);
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_instr_pc", instr_pc, 0);
        checkOutput("rst_imem_en", {31'b0, imem_en}, 0);
        checkOutput("rst_imem_addr", imem_addr, 0);
        restart(32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("first_valid_c%0d", k), {31'b0, instr_valid}, (k == 3) ? 1 : 0);
            if (k == 0) checkOutput("boot_imem_en", {31'b0, imem_en}, 0);
            if (k == 1) begin
                checkOutput("first_imem_en", {31'b0, imem_en}, 1);
                checkOutput("first_imem_addr", imem_addr, 0);
            end
        end
        wd_en = 1'b1;
        hs0 = hs_count;
        repeat (8) applyStimulus(0, 1, 0, 0);
        checkOutput("throughput", hs_count - hs0, 8);

        // Decoder stall: fetch must stop issuing and hold the word.
        wd_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("stall_valid", {31'b0, instr_valid}, 1);
            if (k > 0) checkOutput("stall_imem_en", {31'b0, imem_en}, 0);
        end
        wd_en = 1'b1;
        repeat (10) applyStimulus(0, 1, 0, 0);

        // Redirect with one word queued and one in flight.
        restart(32'h100);
        applyStimulus(0, 1, 1, 32'h100);
        checkOutput("redir_imem_en", {31'b0, imem_en}, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redir_next_valid", {31'b0, instr_valid}, 0);
        checkOutput("redir_issue_en", {31'b0, imem_en}, 1);
        checkOutput("redir_issue_addr", imem_addr, 32'h100);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redir_target_valid", {31'b0, instr_valid}, 1);
        repeat (6) applyStimulus(0, 1, 0, 0);

        // Misaligned redirect target.
        restart(32'h103);
        applyStimulus(0, 1, 1, 32'h103);
        applyStimulus(0, 1, 0, 0);
        checkOutput("align_imem_addr", imem_addr, 32'h100);
        repeat (6) applyStimulus(0, 1, 0, 0);

        // Random backpressure and redirects.
        wd_en = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                tgt = $urandom;
                restart(tgt);
                applyStimulus(0, ($urandom_range(0, 3) != 0), 1, tgt);
            end else begin
                applyStimulus(0, ($urandom_range(0, 3) != 0), 0, 0);
            end
        end
        wd_en = 1'b1;
        repeat (10) applyStimulus(0, 1, 0, 0);

        // Reset in mid-stream with a word in flight.
        wd_en = 1'b0;
        restart(32'h0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("midrst_valid", {31'b0, instr_valid}, 0);
        checkOutput("midrst_instr", instr, NOP);
        checkOutput("midrst_imem_en", {31'b0, imem_en}, 0);
        checkOutput("midrst_imem_addr", imem_addr, 0);
        wd_en = 1'b1;
        repeat (12) applyStimulus(0, 1, 0, 0);

        checkOutput("wrap_seen", wrap_idx, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
